// File: rtl/fpu_float_sqrt_prepare_pkg.sv
// Shared types and helpers for the sqrt operand-prepare stage: float fields,
// special classes, the prepared-result record and its packing function.
package fpu_float_sqrt_prepare_pkg;

  localparam int FPU_FLOAT_BIAS  = 127;
  localparam int FPU_SQRT_ID_MAX = 16;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fpu_float_fields_t;

  typedef enum logic [1:0] {
    FPU_SQRT_NONE = 2'd0,
    FPU_SQRT_ZERO = 2'd1,
    FPU_SQRT_INF  = 2'd2,
    FPU_SQRT_NAN  = 2'd3
  } fpu_sqrt_special_t;

  typedef struct packed {
    logic                       sign;
    fpu_sqrt_special_t          special;
    logic [7:0]                 exponent;
    logic [25:0]                radicand;
    logic [FPU_SQRT_ID_MAX-1:0] id;
  } fpu_sqrt_prepare_result_t;

  typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_OUT} fpu_sqrt_state_t;

  function automatic logic fpu_float_is_zero(fpu_float_fields_t f);
    return (f.exponent == 8'h00) && (f.mantissa == 23'd0);
  endfunction

  function automatic fpu_sqrt_special_t fpu_sqrt_classify(fpu_float_fields_t f);
    if (f.exponent == 8'hFF && f.mantissa != 23'd0) return FPU_SQRT_NAN;
    if (f.sign && !fpu_float_is_zero(f))            return FPU_SQRT_NAN;
    if (fpu_float_is_zero(f))                       return FPU_SQRT_ZERO;
    if (f.exponent == 8'hFF)                        return FPU_SQRT_INF;
    return FPU_SQRT_NONE;
  endfunction

  // IEEE invalid-operation: sqrt of a negative nonzero, or any signalling NaN
  function automatic logic fpu_sqrt_invalid(fpu_float_fields_t f);
    return (f.sign && !fpu_float_is_zero(f)) ||
           (f.exponent == 8'hFF && f.mantissa != 23'd0 && !f.mantissa[22]);
  endfunction

  // m is normalised (m[23]=1); e is the unbiased exponent. An odd e is made
  // even by folding one factor of two into the radicand.
  function automatic fpu_sqrt_prepare_result_t fpu_sqrt_pack(
    logic sign, fpu_sqrt_special_t sp, logic [23:0] m, logic signed [9:0] e,
    logic [FPU_SQRT_ID_MAX-1:0] id);
    fpu_sqrt_prepare_result_t r;
    logic signed [9:0] ee;
    r         = '0;
    r.id      = id;
    r.special = sp;
    ee        = e;
    if (sp == FPU_SQRT_NONE) begin
      if (e[0]) begin
        r.radicand = {1'b1, m[22:0], 2'b00};
        ee         = e - 10'sd1;
      end else begin
        r.radicand = {2'b01, m[22:0], 1'b0};
      end
      r.exponent = 8'((ee >>> 1) + 10'sd127);
    end else if (sp == FPU_SQRT_ZERO) begin
      r.sign = sign;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_float_sqrt_prepare_if.sv
// Operand/result handshake bundle for the sqrt prepare stage.
// FPU_SQRT_PREPARE_FLAGS_EN adds the result_invalid flag.
interface fpu_float_sqrt_prepare_if #(parameter int ID_WIDTH = 4);
  import fpu_float_sqrt_prepare_pkg::*;

  logic                operand_valid;
  logic                operand_ready;
  fpu_float_fields_t   operand;
  logic [ID_WIDTH-1:0] operand_id;
  logic                result_valid;
  logic                result_ready;
  logic [25:0]         result_radicand;
  logic [7:0]          result_exponent;
  fpu_sqrt_special_t   result_special;
  logic                result_sign;
  logic [ID_WIDTH-1:0] result_id;
`ifdef FPU_SQRT_PREPARE_FLAGS_EN
  logic                result_invalid;

  modport master (
    output operand_valid, operand, operand_id, result_ready,
    input  operand_ready, result_valid, result_radicand, result_exponent,
           result_special, result_sign, result_id, result_invalid
  );
  modport slave (
    input  operand_valid, operand, operand_id, result_ready,
    output operand_ready, result_valid, result_radicand, result_exponent,
           result_special, result_sign, result_id, result_invalid
  );
`else
  modport master (
    output operand_valid, operand, operand_id, result_ready,
    input  operand_ready, result_valid, result_radicand, result_exponent,
           result_special, result_sign, result_id
  );
  modport slave (
    input  operand_valid, operand, operand_id, result_ready,
    output operand_ready, result_valid, result_radicand, result_exponent,
           result_special, result_sign, result_id
  );
`endif

endinterface

// File: rtl/fpu_float_sqrt_prepare_lzc.sv
// Leading-zero count of a WIDTH-bit window, saturating at WIDTH when all zero.
module fpu_leading_zero_count #(
  parameter int WIDTH = 4,
  parameter int CW    = 5
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);

  // Scanning upward lets the highest set bit win the final assignment
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (bits[i]) count = CW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/fpu_float_sqrt_prepare.sv
// Sqrt operand-prepare stage: classify, normalise denormals, even the exponent.
// Optional FPU_SQRT_PREPARE_FLAGS_EN adds the registered result_invalid flag.
module fpu_float_sqrt_prepare
  import fpu_float_sqrt_prepare_pkg::*;
#(
  parameter int NORM_SHIFT = 4,
  parameter int ID_WIDTH   = 4
) (
  input logic                    clk,
  input logic                    rst,
  fpu_float_sqrt_prepare_if.slave bus
);

  fpu_sqrt_state_t            state, state_nxt;
  fpu_sqrt_prepare_result_t   res;
  fpu_float_fields_t          op;
  fpu_sqrt_special_t          op_special;
  logic                       op_denorm, accept, norm_done;
  logic [23:0]                m_q, m_shift;
  logic signed [9:0]          e_q, e_shift, e_op;
  logic [ID_WIDTH-1:0]        id_q;
  logic [FPU_SQRT_ID_MAX-1:0] op_id_w, norm_id_w;
  logic [4:0]                 sh;
  logic                       unused_id;

  assign op         = bus.operand;
  assign op_special = fpu_sqrt_classify(op);
  assign op_denorm  = (op_special == FPU_SQRT_NONE) && (op.exponent == 8'h00);
  assign e_op       = signed'({2'b00, op.exponent}) - 10'sd127;
  assign op_id_w    = FPU_SQRT_ID_MAX'(bus.operand_id);
  assign norm_id_w  = FPU_SQRT_ID_MAX'(id_q);

  assign bus.operand_ready = (state == ST_IDLE) || (state == ST_OUT && bus.result_ready);
  assign accept            = bus.operand_valid && bus.operand_ready;

  // Shift is capped by the leading zeros in the window, so m never overshoots
  fpu_leading_zero_count #(.WIDTH(NORM_SHIFT), .CW(5)) u_lzc (
    .bits  (m_q[23 -: NORM_SHIFT]),
    .count (sh)
  );

  assign m_shift   = m_q << sh;
  assign e_shift   = e_q - signed'({5'd0, sh});
  assign norm_done = m_shift[23];

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = op_denorm ? ST_NORM : ST_OUT;
      ST_NORM: if (norm_done) state_nxt = ST_OUT;
      ST_OUT:  if (bus.result_ready)
                 state_nxt = accept ? (op_denorm ? ST_NORM : ST_OUT) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Finishing in the same cycle as the last shift keeps latency at 1+ceil(lz/N)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q  <= '0;
      e_q  <= '0;
      id_q <= '0;
      res  <= '0;
    end else if (accept) begin
      if (op_denorm) begin
        m_q  <= {1'b0, op.mantissa};
        e_q  <= -10'sd126;
        id_q <= bus.operand_id;
      end else begin
        res <= fpu_sqrt_pack(op.sign, op_special, {1'b1, op.mantissa}, e_op, op_id_w);
      end
    end else if (state == ST_NORM) begin
      m_q <= m_shift;
      e_q <= e_shift;
      if (norm_done)
        res <= fpu_sqrt_pack(1'b0, FPU_SQRT_NONE, m_shift, e_shift, norm_id_w);
    end
  end

`ifdef FPU_SQRT_PREPARE_FLAGS_EN
  logic invalid_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst)        invalid_q <= 1'b0;
    else if (accept) invalid_q <= fpu_sqrt_invalid(op);
  assign bus.result_invalid = invalid_q;
`endif

  assign bus.result_valid    = (state == ST_OUT);
  assign bus.result_radicand = res.radicand;
  assign bus.result_exponent = res.exponent;
  assign bus.result_special  = res.special;
  assign bus.result_sign     = res.sign;
  assign bus.result_id       = res.id[ID_WIDTH-1:0];
  assign unused_id           = ^res.id;

endmodule
